// File: rtl/spi_dac8512_rx_if.sv
// spi_dac8512_rx_if: serial pins and emulated DAC outputs of the SPI DAC receiver
interface spi_dac8512_rx_if #(
  parameter int NBIT = 12
);
  logic            NCS;
  logic            SCLK;
  logic            SDAT;
  logic            NLD;
  logic            NCLR;
  logic [NBIT-1:0] DOUT;
  logic [NBIT-1:0] IREG;
  logic            ok;
  logic            err;
  logic            busy;
  modport master (output NCS, SCLK, SDAT, NLD, NCLR, input DOUT, IREG, ok, err, busy);
  modport slave  (input NCS, SCLK, SDAT, NLD, NCLR, output DOUT, IREG, ok, err, busy);
endinterface

// File: rtl/spi_dac8512_rx.sv
// spi_dac8512_rx: DAC8512-style SPI receiver with input register, load strobe and level clear
module spi_dac8512_rx #(
  parameter int NBIT  = 12,
  parameter int NSYNC = 2
) (
  input logic               clk,
  input logic               NRST,
  spi_dac8512_rx_if.slave   bus
);
  localparam int CW = $clog2(NBIT + 2);
  // Pin vector order {NCLR, NLD, SDAT, SCLK, NCS}; idle levels are high except SDAT.
  localparam logic [4:0] SYNC_RST = 5'b11011;
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
  logic [4:0]      r_sync [NSYNC];
  logic [4:0]      r_hist;
  logic [4:0]      w_s;
  logic            w_ncs_fall, w_ncs_rise, w_sclk_rise, w_sdat, w_nld_fall, w_clr;
  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [NBIT-1:0] r_sh, w_sh_nxt;
  logic            w_accept, w_reject;
  logic [NBIT-1:0] r_ireg, r_dout;
  logic            r_valid, r_ok, r_err;
  assign w_s         = r_sync[NSYNC-1];
  assign w_ncs_fall  = r_hist[0] & ~w_s[0];
  assign w_ncs_rise  = ~r_hist[0] & w_s[0];
  // Serial clock edges only count while the chip select is (synchronized) low.
  assign w_sclk_rise = ~r_hist[1] & w_s[1] & ~w_s[0];
  assign w_sdat      = w_s[2];
  assign w_nld_fall  = r_hist[3] & ~w_s[3];
  assign w_clr       = ~w_s[4];
  // Synchronizer chain for all five pins plus one history stage for edge detection.
  always_ff @(posedge clk or negedge NRST) begin
    if (!NRST) begin
      for (int i = 0; i < NSYNC; i++) r_sync[i] <= SYNC_RST;
      r_hist <= SYNC_RST;
    end else begin
      r_sync[0] <= {bus.NCLR, bus.NLD, bus.SDAT, bus.SCLK, bus.NCS};
      for (int i = 1; i < NSYNC; i++) r_sync[i] <= r_sync[i-1];
      r_hist <= w_s;
    end
  end
  // Frame FSM next state, bit counter and shift register updates.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sh_nxt    = r_sh;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ncs_fall) begin
          w_state_nxt = SHIFT;
          w_cnt_nxt   = '0;
          w_sh_nxt    = '0;
        end
      end
      SHIFT: begin
        if (w_sclk_rise) begin
          w_sh_nxt  = {r_sh[NBIT-2:0], w_sdat};
          w_cnt_nxt = (r_cnt == CW'(NBIT + 1)) ? r_cnt : r_cnt + 1'b1;
        end
        if (w_ncs_rise) w_state_nxt = CHECK;
      end
      CHECK: begin
        w_state_nxt = IDLE;
        w_accept    = (r_cnt == CW'(NBIT));
        w_reject    = (r_cnt != CW'(NBIT));
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  // FSM state register.
  always_ff @(posedge clk or negedge NRST) begin
    if (!NRST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sh    <= w_sh_nxt;
    end
  end
  // Input/DAC registers: clear wins over load and accept; load takes IREG before this cycle's accept.
  always_ff @(posedge clk or negedge NRST) begin
    if (!NRST) begin
      r_ireg  <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_ok    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_reject;
      r_ok  <= w_nld_fall & r_valid & ~w_clr;
      if (w_clr) begin
        r_ireg  <= '0;
        r_dout  <= '0;
        r_valid <= 1'b0;
      end else begin
        if (w_nld_fall && r_valid) r_dout <= r_ireg;
        if (w_accept) begin
          r_ireg  <= r_sh;
          r_valid <= 1'b1;
        end
      end
    end
  end
  assign bus.DOUT = r_dout;
  assign bus.IREG = r_ireg;
  assign bus.ok   = r_ok;
  assign bus.err  = r_err;
  assign bus.busy = (r_state == SHIFT);
endmodule

// File: tb/tb_spi_dac8512_rx.sv
// tb_spi_dac8512_rx: randomized SPI frames, loads and clears checked against a frame-level model
module tb_spi_dac8512_rx;
  localparam int NBIT  = 12;
  localparam int NSYNC = 2;
  localparam int MAXE  = 40000;
  logic clk  = 1'b0;
  logic NRST = 1'b0;
  spi_dac8512_rx_if #(.NBIT(NBIT)) bus ();
  spi_dac8512_rx #(.NBIT(NBIT), .NSYNC(NSYNC)) dut (.clk(clk), .NRST(NRST), .bus(bus));
  always #5 clk = ~clk;
  int n_checks = 0;
  int n_errors = 0;
  int edge_n   = 0;
  int ok_cnt   = 0;
  int err_cnt  = 0;
  // Pin history per clock edge and per-edge scheduled frame events.
  bit              nld_h  [MAXE];
  bit              nclr_h [MAXE];
  bit              chk_at [MAXE];
  int              chk_n  [MAXE];
  logic [NBIT-1:0] chk_v  [MAXE];
  bit              bset   [MAXE];
  bit              bclr   [MAXE];
  logic [NBIT-1:0] m_dout = '0;
  logic [NBIT-1:0] m_ireg = '0;
  bit m_valid = 0, m_ok = 0, m_err = 0, m_busy = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", nm, edge_n, act, exp);
    end
  endtask
  // Reference model: pins seen at edge k take effect NSYNC+1 edges later; frames are judged by bit count.
  initial forever begin
    bit cl, ld, good;
    int e;
    @(posedge clk);
    edge_n++;
    e = edge_n;
    if (e < MAXE) begin
      nld_h[e]  = bus.NLD;
      nclr_h[e] = bus.NCLR;
      if (!NRST) begin
        m_dout = '0; m_ireg = '0; m_valid = 0; m_ok = 0; m_err = 0; m_busy = 0;
      end else begin
        cl   = (e > NSYNC) && !nclr_h[e-NSYNC];
        ld   = (e > NSYNC + 1) && nld_h[e-NSYNC-1] && !nld_h[e-NSYNC];
        good = chk_at[e] && (chk_n[e] == NBIT);
        m_ok  = ld && m_valid && !cl;
        m_err = chk_at[e] && !good;
        if (cl) begin
          m_dout = '0; m_ireg = '0; m_valid = 0;
        end else begin
          if (m_ok) m_dout = m_ireg;
          if (good) begin m_ireg = chk_v[e]; m_valid = 1; end
        end
        if (bset[e]) m_busy = 1;
        if (bclr[e]) m_busy = 0;
      end
    end
  end
  // Every cycle, compare all outputs against the model away from the clock edge.
  initial forever begin
    @(posedge clk);
    #1;
    chk("dout", 32'(bus.DOUT), 32'(m_dout));
    chk("ireg", 32'(bus.IREG), 32'(m_ireg));
    chk("ok",   32'(bus.ok),   32'(m_ok));
    chk("err",  32'(bus.err),  32'(m_err));
    chk("busy", 32'(bus.busy), 32'(m_busy));
    if (bus.ok)  ok_cnt++;
    if (bus.err) err_cnt++;
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic start_frame(input int nbits, input logic [31:0] v, input int half);
    bus.NCS = 1'b0;
    bset[edge_n + 1 + NSYNC] = 1;
    cyc(2);
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.SCLK = 1'b0;
      bus.SDAT = v[i];
      cyc(half);
      bus.SCLK = 1'b1;
      cyc(half);
    end
  endtask
  task automatic end_frame(input int nbits, input logic [31:0] v);
    int k;
    bus.NCS = 1'b1;
    k = edge_n + 1;
    bclr[k + NSYNC]       = 1;
    chk_at[k + NSYNC + 1] = 1;
    chk_n[k + NSYNC + 1]  = nbits;
    chk_v[k + NSYNC + 1]  = v[NBIT-1:0];
  endtask
  task automatic frame(input int nbits, input logic [31:0] v, input int half, input int gap);
    start_frame(nbits, v, half);
    end_frame(nbits, v);
    cyc(gap);
  endtask
  task automatic nld(input int len);
    bus.NLD = 1'b0;
    cyc(len);
    bus.NLD = 1'b1;
    cyc(6);
  endtask
  task automatic nclr(input int len);
    bus.NCLR = 1'b0;
    cyc(len);
    bus.NCLR = 1'b1;
    cyc(6);
  endtask
  task automatic stray_sclk(input int n);
    repeat (n) begin
      bus.SCLK = 1'b0;
      bus.SDAT = 1'($urandom);
      cyc(4);
      bus.SCLK = 1'b1;
      cyc(4);
    end
  endtask
  initial begin
    int o0, e0, op, nb, r;
    logic [31:0] v;
    bus.NCS = 1'b1; bus.SCLK = 1'b1; bus.SDAT = 1'b0; bus.NLD = 1'b1; bus.NCLR = 1'b1;
    cyc(3);
    chk("reset_dout", 32'(bus.DOUT), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    NRST = 1'b1;
    cyc(4);
    // Short frame is rejected and a later load does nothing.
    e0 = err_cnt; o0 = ok_cnt;
    frame(NBIT - 1, 32'h5A5, 8, 6);
    nld(4);
    chk("short_err_count", 32'(err_cnt - e0), 32'd1);
    chk("short_ok_count",  32'(ok_cnt - o0),  32'd0);
    chk("short_ireg",      32'(bus.IREG),     32'h0);
    // Nominal 0xA5C frame with SCLK period 8 and a 4-cycle load strobe.
    frame(NBIT, 32'hA5C, 4, 6);
    chk("a5c_ireg",  32'(bus.IREG), 32'hA5C);
    chk("model_ireg", 32'(m_ireg),  32'hA5C);
    o0 = ok_cnt;
    nld(4);
    chk("a5c_dout",     32'(bus.DOUT),     32'hA5C);
    chk("a5c_ok_count", 32'(ok_cnt - o0),  32'd1);
    // Overrun frame is rejected and IREG keeps its value.
    e0 = err_cnt;
    frame(NBIT + 2, 32'h3FFF, 4, 6);
    chk("long_err_count", 32'(err_cnt - e0), 32'd1);
    chk("long_ireg",      32'(bus.IREG),     32'hA5C);
    // Clear wipes both registers and the valid flag.
    frame(NBIT, 32'h7FF, 4, 6);
    nld(4);
    chk("pre_clr_dout", 32'(bus.DOUT), 32'h7FF);
    nclr(5);
    chk("clr_dout", 32'(bus.DOUT), 32'h0);
    chk("clr_ireg", 32'(bus.IREG), 32'h0);
    o0 = ok_cnt;
    nld(4);
    chk("clr_nld_ok_count", 32'(ok_cnt - o0), 32'd0);
    // Reset mid-frame abandons it silently; the next full frame is accepted.
    start_frame(6, 32'h2D, 4);
    NRST = 1'b0; bus.NCS = 1'b1; bus.SCLK = 1'b1;
    cyc(4);
    NRST = 1'b1;
    cyc(4);
    e0 = err_cnt;
    frame(NBIT, 32'h001, 4, 6);
    nld(4);
    chk("rst_err_count", 32'(err_cnt - e0), 32'd0);
    chk("rst_dout",      32'(bus.DOUT),     32'h001);
    // Back-to-back frames, one load after the second.
    o0 = ok_cnt;
    frame(NBIT, 32'h123, 4, 4);
    frame(NBIT, 32'h456, 4, 6);
    nld(4);
    chk("b2b_dout",     32'(bus.DOUT),    32'h456);
    chk("b2b_ok_count", 32'(ok_cnt - o0), 32'd1);
    // Load edge coincides with the accept: DOUT takes the previous IREG.
    frame(NBIT, 32'h789, 4, 1);
    nld(4);
    chk("same_dout", 32'(bus.DOUT), 32'h456);
    chk("same_ireg", 32'(bus.IREG), 32'h789);
    nld(4);
    chk("same_dout2", 32'(bus.DOUT), 32'h789);
    // Clear in the same cycle as accept and load wins over both.
    o0 = ok_cnt;
    frame(NBIT, 32'h321, 4, 1);
    bus.NCLR = 1'b0; bus.NLD = 1'b0;
    cyc(4);
    bus.NCLR = 1'b1; bus.NLD = 1'b1;
    cyc(6);
    chk("prio_ireg", 32'(bus.IREG), 32'h0);
    chk("prio_dout", 32'(bus.DOUT), 32'h0);
    nld(4);
    chk("prio_ok_count", 32'(ok_cnt - o0), 32'd0);
    // Serial clocks with chip select high are ignored.
    frame(NBIT, 32'hBEE, 4, 6);
    stray_sclk(5);
    chk("stray_ireg", 32'(bus.IREG), 32'hBEE);
    // Randomized mix of frames, loads, clears and stray clocks.
    for (int it = 0; it < 70; it++) begin
      op = $urandom_range(0, 5);
      if (op <= 2) begin
        r  = $urandom_range(0, 3);
        nb = (r < 2) ? NBIT : (r == 2) ? $urandom_range(1, NBIT - 1) : $urandom_range(NBIT + 1, NBIT + 3);
        v  = $urandom;
        frame(nb, v, $urandom_range(NSYNC + 2, 6), $urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) nld($urandom_range(2, 5));
        cyc(NSYNC + 3);
      end else if (op == 3) begin
        nld($urandom_range(2, 6));
      end else if (op == 4) begin
        nclr($urandom_range(2, 6));
      end else begin
        stray_sclk($urandom_range(1, 3));
      end
    end
    cyc(10);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/spi_dac8512_rx.md
SPI_DAC8512_RX -- requirements
Module: spi_dac8512_rx

Interface
- REQ-001 The module SHALL have parameter NBIT, default 12, giving the data word width in bits.
- REQ-002 The module SHALL have parameter NSYNC, default 2, giving the number of synchronizer flip-flop stages per serial input.
- REQ-003 clk  input  1  system clock; all state SHALL change on its rising edge.
- REQ-004 NRST  input  1  reset; one clock, reset is asynchronous and active-low.
- REQ-005 NCS  input  1  active-low chip select from the SPI master; asynchronous to clk.
- REQ-006 SCLK  input  1  serial clock from the master; asynchronous to clk.
- REQ-007 SDAT  input  1  serial data, MSB first, valid on the rising edge of SCLK.
- REQ-008 NLD  input  1  active-low load strobe; transfers the input register to the DAC register.
- REQ-009 NCLR  input  1  active-low level clear.
- REQ-010 DOUT  output  NBIT  DAC register contents, i.e. the emulated converter code.
- REQ-011 IREG  output  NBIT  input register contents, i.e. the last complete frame.
- REQ-012 ok  output  1  one-cycle pulse when DOUT is loaded by NLD.
- REQ-013 err  output  1  one-cycle pulse when a frame is rejected.
- REQ-014 busy  output  1  high while in state SHIFT.

Function
- REQ-015 The block SHALL pass each of NCS, SCLK, SDAT, NLD and NCLR through an NSYNC-stage synchronizer followed by one history register per input.
- REQ-016 An edge SHALL be detected as a difference between the last synchronizer stage and its history register, which gives a detection latency of NSYNC+1 clk cycles from the pin.
- REQ-017 The FSM SHALL have the states IDLE, SHIFT and CHECK, and SHALL reset to IDLE.
- REQ-018 In IDLE, a synchronized falling edge of NCS SHALL clear the bit counter, clear the shift register, and move the FSM to SHIFT.
- REQ-019 In SHIFT, each synchronized rising edge of SCLK SHALL shift the synchronized SDAT into the shift register LSB, with the older bits moving toward the MSB.
- REQ-020 Each such SCLK edge SHALL increment the bit counter, which saturates at NBIT+1.
- REQ-021 The shift register SHALL always hold the last NBIT bits received.
- REQ-022 SCLK edges seen while NCS is synchronized high SHALL be ignored.
- REQ-023 In SHIFT, a synchronized rising edge of NCS SHALL move the FSM to CHECK.
- REQ-024 In CHECK, if the bit counter equals NBIT, the shift register SHALL be copied into IREG and the valid flag SHALL be set.
- REQ-025 In CHECK, any other bit count (short or overrun) SHALL pulse err for one cycle and leave IREG and the valid flag unchanged.
- REQ-026 CHECK SHALL always return to IDLE after one cycle.
- REQ-027 A synchronized falling edge of NLD with the valid flag set SHALL load DOUT from IREG and pulse ok for one cycle in any FSM state; the valid flag SHALL remain set.
- REQ-028 An NLD falling edge with the valid flag clear SHALL have no effect.
- REQ-029 If the NLD edge and the CHECK IREG update fall in the same cycle, DOUT SHALL receive the old IREG value.
- REQ-030 While NCLR is synchronized low, DOUT and IREG SHALL be held at 0, the valid flag SHALL be held clear, and ok SHALL be suppressed.
- REQ-031 NCLR SHALL NOT affect the FSM, so a frame in progress completes and is accepted once NCLR is high.
- REQ-032 NCLR SHALL have priority over NLD and CHECK in the same cycle.
- REQ-033 The master SHALL keep SCLK high and low each for at least NSYNC+2 clk cycles, and SDAT stable from 1 clk before to NSYNC+1 clk after each SCLK rise; faster SCLK is out of scope and behaviour under it is unspecified.

Reset
- REQ-034 While NRST is low, all synchronizer and history registers SHALL be set to 1 for NCS, NLD, NCLR and SCLK, and to 0 for SDAT.
- REQ-035 While NRST is low, the FSM SHALL be in IDLE, the counter 0, the shift register, IREG and DOUT 0, the valid flag clear, and ok, err and busy 0.
- REQ-036 Reset asserted mid-frame SHALL abandon the frame with no err pulse.
- REQ-037 After NRST deasserts, the first frame SHALL start only on a fresh NCS falling edge.

Verification
- REQ-038 Frame 0xA5C (12 bits, SCLK period 8 clk) followed by NLD low for 4 clk -> IREG=0xA5C one cycle after CHECK, then DOUT=0xA5C with ok high for exactly 1 cycle, NSYNC+1 cycles after the NLD pin fall.
- REQ-039 An 11-bit frame, then NLD -> err pulses once, and IREG, DOUT and ok are unchanged (0 after reset).
- REQ-040 A 14-bit frame -> err pulses once and IREG stays at its prior value.
- REQ-041 DOUT=0x7FF, then NCLR low for 5 clk -> DOUT=0 and IREG=0; a subsequent NLD produces no ok until a new valid frame arrives.
- REQ-042 NRST low after 6 of 12 bits, released, then a full frame 0x001 + NLD -> no err, DOUT=0x001.
- REQ-043 Back-to-back frames 0x123 and 0x456 with NLD only after the second -> DOUT=0x456 and exactly one ok pulse.
